bcd_scan_display: RTL and testbench

Parametrised multi-channel decimal display engine driving a time-multiplexed common-anode 7-segment bank. It snapshots CHANNELS binary words on request and converts them to BCD with a serial double-dabble sequencer. It then scans the committed digits across CHANNELS×DIGITS_PER_CH anodes at a programmable refresh rate, with per-channel overflow indication. It sits between the CPU register taps and the board display pins, replacing the separate binary-to-BCD and scan blocks.

---
 rtl/seg_disp_pkg.sv | 40 ++++
 rtl/bcd_dd_serial.sv | 59 +++++
 rtl/bcd_scan_display.sv | 186 ++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - FSM states and active-low segment encodings for bcd_scan_display
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Segment order is g..a (bit 6 = g), low = lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] i_nib);
    case (i_nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// rtl/bcd_dd_serial.sv - one-channel serial double-dabble converter with overflow detect
// o_bcd/o_ovf present the result of the shift in progress; o_done marks the final shift.
module bcd_dd_serial #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [BIN_W-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf,
  output logic                  o_done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_shifted;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_shifted = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign o_bcd     = w_shifted;
  assign o_ovf     = r_ovf | w_adj[BCD_W-1];
  assign o_done    = i_shift && (r_cnt == CNT_W'(BIN_W - 1));

  // A load wins over a shift so the next channel can start on the final-shift edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_shifted;
      r_ovf <= o_ovf;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - snapshot binary channels, convert to BCD, scan a common-anode bank
// Define LEADING_ZERO_BLANK_EN to blank zero digits above each channel's leading nonzero digit.
module bcd_scan_display
  import seg_disp_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int BIN_W         = 8,
  parameter int DIGITS_PER_CH = 4,
  parameter int REFRESH_DIV   = 100000
) (
  input  logic                              clk,
  input  logic                              CLEARn,
  input  logic [CHANNELS*BIN_W-1:0]         value,
  input  logic                              load,
  input  logic [CHANNELS*DIGITS_PER_CH-1:0] dp_mask,
  output logic                              busy,
  output logic [CHANNELS*DIGITS_PER_CH-1:0] an,
  output logic [6:0]                        seg,
  output logic                              dp
);

  localparam int ANODES = CHANNELS * DIGITS_PER_CH;
  localparam int BCD_W  = 4 * DIGITS_PER_CH;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDX_W  = (ANODES > 1) ? $clog2(ANODES) : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] LAST_DIG = IDX_W'(ANODES - 1);

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_pending;
  logic [CH_W-1:0]             r_ch;
  logic [CHANNELS*BIN_W-1:0]   r_snap;
  logic [BCD_W-1:0]            r_res  [CHANNELS];
  logic [BCD_W-1:0]            r_disp [CHANNELS];
  logic [CHANNELS-1:0]         r_res_ovf;
  logic [CHANNELS-1:0]         r_disp_ovf;
  logic [REF_W-1:0]            r_refresh;
  logic [IDX_W-1:0]            r_digit;
  logic [ANODES-1:0]           r_an;
  logic [6:0]                  r_seg;
  logic                        r_dp;

  logic [BIN_W-1:0]            w_snap [CHANNELS];
  logic                        w_conv_load;
  logic                        w_conv_shift;
  logic [BIN_W-1:0]            w_conv_bin;
  logic [BCD_W-1:0]            w_conv_bcd;
  logic                        w_conv_ovf;
  logic                        w_conv_done;
  logic                        w_wrap;
  logic [IDX_W-1:0]            w_digit_next;
  logic [6:0]                  w_seg_anode [ANODES];

  assign busy = r_busy;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_snap
    assign w_snap[c] = r_snap[c*BIN_W +: BIN_W];
  end

  always_comb begin
    w_conv_load  = 1'b0;
    w_conv_bin   = value[BIN_W-1:0];
    w_conv_shift = (r_state == ST_CONV);
    case (r_state)
      ST_IDLE:   w_conv_load = load;
      ST_COMMIT: w_conv_load = r_pending || load;
      ST_CONV: begin
        if (w_conv_done && (r_ch != LAST_CH)) begin
          w_conv_load = 1'b1;
          w_conv_bin  = w_snap[r_ch + 1'b1];
        end
      end
      default: w_conv_load = 1'b0;
    endcase
  end

  bcd_dd_serial #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS_PER_CH)
  ) u_dd (
    .clk     (clk),
    .rst_n   (CLEARn),
    .i_load  (w_conv_load),
    .i_shift (w_conv_shift),
    .i_bin   (w_conv_bin),
    .o_bcd   (w_conv_bcd),
    .o_ovf   (w_conv_ovf),
    .o_done  (w_conv_done)
  );

  always_ff @(posedge clk or negedge CLEARn) begin
    if (!CLEARn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_pending  <= 1'b0;
      r_ch       <= '0;
      r_snap     <= '0;
      r_res      <= '{default: '0};
      r_res_ovf  <= '0;
      r_disp     <= '{default: '0};
      r_disp_ovf <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_snap  <= value;
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (load) r_pending <= 1'b1;
          if (w_conv_done) begin
            r_res[r_ch]     <= w_conv_bcd;
            r_res_ovf[r_ch] <= w_conv_ovf;
            if (r_ch == LAST_CH) r_state <= ST_COMMIT;
            else                 r_ch    <= r_ch + 1'b1;
          end
        end
        ST_COMMIT: begin
          // All channels land together so the scan never mixes old and new values
          r_disp     <= r_res;
          r_disp_ovf <= r_res_ovf;
          if (r_pending || load) begin
            r_snap    <= value;
            r_ch      <= '0;
            r_pending <= 1'b0;
            r_state   <= ST_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar d = 0; d < DIGITS_PER_CH; d++) begin : g_dig
      logic w_lz;
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 0) begin : g_ls
        assign w_lz = 1'b0;
      end else begin : g_hi
        assign w_lz = (r_disp[c][BCD_W-1:4*d] == '0);
      end
`else
      assign w_lz = 1'b0;
`endif
      assign w_seg_anode[c*DIGITS_PER_CH+d] = r_disp_ovf[c] ? SEG_DASH  :
                                              w_lz          ? SEG_BLANK :
                                              seg_decode(r_disp[c][4*d +: 4]);
    end
  end

  assign w_wrap       = (r_refresh == REF_W'(REFRESH_DIV - 1));
  assign w_digit_next = !w_wrap                ? r_digit :
                        (r_digit == LAST_DIG)  ? '0      : r_digit + 1'b1;

  // Outputs load from the next digit index, so anode and segments switch on the same edge
  always_ff @(posedge clk or negedge CLEARn) begin
    if (!CLEARn) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_an      <= '1;
      r_seg     <= SEG_BLANK;
      r_dp      <= 1'b1;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
      r_digit   <= w_digit_next;
      if (w_wrap || (r_an == '1)) begin
        r_an  <= ~(ANODES'(1) << w_digit_next);
        r_seg <= w_seg_anode[w_digit_next];
        r_dp  <= ~dp_mask[w_digit_next];
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display (4-digit and 2-digit builds)
module tb_bcd_scan_display;

  localparam int RDIV = 4;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = SB;
`else
  localparam logic [6:0] Z = S0;
`endif

  typedef struct packed {
    logic [7:0]  busy_cyc;
    logic [55:0] segs;
    logic [7:0]  dpm;
  } exp_t;

  logic        clk = 1'b0;
  logic        CLEARn;
  logic [15:0] value1, value2;
  logic        load1, load2;
  logic [7:0]  dp_mask1;
  logic [3:0]  dp_mask2;
  logic        busy1, busy2, dp1, dp2;
  logic [7:0]  an1;
  logic [3:0]  an2;
  logic [6:0]  seg1, seg2;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic        mon_act [2];
  logic [7:0]  an_v    [2];
  logic [6:0]  seg_v   [2];
  logic        dp_v    [2];
  logic        busy_v  [2];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.CHANNELS(2), .BIN_W(8), .DIGITS_PER_CH(4), .REFRESH_DIV(RDIV)) u_dut (
    .clk(clk), .CLEARn(CLEARn), .value(value1), .load(load1), .dp_mask(dp_mask1),
    .busy(busy1), .an(an1), .seg(seg1), .dp(dp1));

  bcd_scan_display #(.CHANNELS(2), .BIN_W(8), .DIGITS_PER_CH(2), .REFRESH_DIV(RDIV)) u_dut2 (
    .clk(clk), .CLEARn(CLEARn), .value(value2), .load(load2), .dp_mask(dp_mask2),
    .busy(busy2), .an(an2), .seg(seg2), .dp(dp2));

  assign an_v[0]   = an1;
  assign an_v[1]   = {4'hF, an2};
  assign seg_v[0]  = seg1;
  assign seg_v[1]  = seg2;
  assign dp_v[0]   = dp1;
  assign dp_v[1]   = dp2;
  assign busy_v[0] = busy1;
  assign busy_v[1] = busy2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int zero_idx(input logic [7:0] a);
    zero_idx = -1;
    for (int i = 7; i >= 0; i--) if (!a[i]) zero_idx = i;
  endfunction

  for (genvar m = 0; m < 2; m++) begin : g_mon
    localparam int NA = (m == 0) ? 8 : 4;
    initial begin
      int         bc, cyc, idx, first, prev;
      exp_t       e;
      logic [7:0] old;
      logic       exp_dp;
      bc = 0;
      mon_act[m] = 1'b0;
      forever begin
        @(negedge clk);
        if (!CLEARn) bc = 0;
        else if (busy_v[m]) bc++;
        else if (bc != 0) begin
          mon_act[m] = 1'b1;
          if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk("sb_has_entry", 64'(0), 64'(1));
          end else begin
            e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("busy_cycles", 64'(bc), 64'(e.busy_cyc));
            old = an_v[m];
            cyc = 0;
            while (an_v[m] == old && cyc < 2*RDIV) begin @(negedge clk); cyc++; end
            chk("first_slot", 64'(an_v[m] != old), 64'(1));
            first = zero_idx(an_v[m]);
            prev  = first;
            for (int s = 0; s < NA; s++) begin
              idx = zero_idx(an_v[m]);
              chk("an_onehot", 64'($countones(~an_v[m])), 64'(1));
              if (s > 0) chk("scan_order", 64'(idx), 64'((prev + 1) % NA));
              chk("seg", 64'(seg_v[m]), 64'(e.segs[idx*7 +: 7]));
              exp_dp = ~e.dpm[idx];
              chk("dp", 64'(dp_v[m]), 64'(exp_dp));
              prev = idx;
              old  = an_v[m];
              cyc  = 0;
              while (an_v[m] == old && cyc < 2*RDIV) begin @(negedge clk); cyc++; end
              chk("slot_len", 64'(cyc), 64'(RDIV));
            end
            chk("scan_wrap", 64'(zero_idx(an_v[m])), 64'(first));
          end
          bc = 0;
          mon_act[m] = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input int m);
    int c;
    c = 0;
    repeat (2) @(negedge clk);
    while (((m == 0 ? sb0.size() : sb1.size()) != 0 || mon_act[m] || busy_v[m]) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 64'(c < 400), 64'(1));
  endtask

  task automatic run1(input logic [15:0] v, input logic [7:0] msk, input exp_t e);
    @(negedge clk);
    sb0.push_back(e);
    value1 = v; dp_mask1 = msk; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    wait_idle(0);
  endtask

  task automatic run2(input logic [15:0] v, input logic [3:0] msk, input exp_t e);
    @(negedge clk);
    sb1.push_back(e);
    value2 = v; dp_mask2 = msk; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    wait_idle(1);
  endtask

  initial begin
    int   idx;
    logic [6:0] exp_seg;
    CLEARn = 1'b0; load1 = 1'b0; load2 = 1'b0;
    value1 = '0; value2 = '0; dp_mask1 = '0; dp_mask2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 64'(an1), 64'(8'hFF));
    chk("rst_seg", 64'(seg1), 64'(SB));
    chk("rst_dp", 64'(dp1), 64'(1));
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_an2", 64'(an2), 64'(4'hF));
    CLEARn = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_an", 64'(an1), 64'(8'hFE));
    chk("first_edge_seg", 64'(seg1), 64'(S0));
    chk("first_edge_dp", 64'(dp1), 64'(1));

    run1({8'd200, 8'd7},   8'h81, {8'd17, {Z, S2, S0, S0, Z, Z, Z, S7},  8'h81});
    run1({8'd95, 8'd128},  8'h88, {8'd17, {Z, Z, S9, S5, Z, S1, S2, S8}, 8'h88});
    run1({8'd0, 8'd255},   8'h10, {8'd17, {Z, Z, Z, S0, Z, S2, S5, S5},  8'h10});
    run2({8'd42, 8'd255},  4'h2,  {8'd17, {SB, SB, SB, SB, S4, S2, SD, SD}, 8'h02});
    run2({8'd9, 8'd99},    4'h8,  {8'd17, {SB, SB, SB, SB, Z, S9, S9, S9},  8'h08});

    // load arriving mid-conversion restarts straight from COMMIT
    @(negedge clk);
    sb0.push_back({8'd34, {Z, Z, Z, S1, Z, Z, Z, S9}, 8'h20});
    value1 = {8'd55, 8'd128}; dp_mask1 = 8'h20; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    repeat (4) @(negedge clk);
    value1 = {8'd1, 8'd9}; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    wait_idle(0);

    @(negedge clk);
    dp_mask1 = 8'h00; value1 = {8'd200, 8'd7}; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    repeat (4) @(negedge clk);
    CLEARn = 1'b0;
    #1;
    chk("abort_busy", 64'(busy1), 64'(0));
    chk("abort_an", 64'(an1), 64'(8'hFF));
    chk("abort_seg", 64'(seg1), 64'(SB));
    repeat (2) @(negedge clk);
    CLEARn = 1'b1;
    @(posedge clk); #1;
    chk("abort_first_an", 64'(an1), 64'(8'hFE));
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      idx = zero_idx(an1);
      exp_seg = (idx == 0 || idx == 4) ? S0 : Z;
      chk("abort_digits", 64'(seg1), 64'(exp_seg));
      chk("abort_busy_low", 64'(busy1), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
